// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, ALU function codes and FSM state encoding shared by alu_seq.
// Build option: ALU_SEQ_MUL_EN adds the MUL state (4x4 shift-add multiply).
package alu_seq_pkg;

   // Command opcodes; 0x0-0x7 are forwarded to the ALU as {L, ALUOp}
   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_NEGA = 4'h2;
   localparam logic [3:0] OP_NEGB = 4'h3;
   localparam logic [3:0] OP_LOG0 = 4'h4;
   localparam logic [3:0] OP_LOG1 = 4'h5;
   localparam logic [3:0] OP_LOG2 = 4'h6;
   localparam logic [3:0] OP_LOG3 = 4'h7;
   localparam logic [3:0] OP_LOAD = 4'h8;
   localparam logic [3:0] OP_MUL  = 4'h9;
   localparam logic [3:0] OP_CLR  = 4'hA;

   // ALU arithmetic function codes (L = 0)
   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_NEGA = 2'b10;
   localparam logic [1:0] ALUOP_NEGB = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
`ifdef ALU_SEQ_MUL_EN
      ST_MUL  = 2'd2,
`endif
      ST_RESP = 2'd3
   } state_t;

endpackage

// File: rtl/alu_seq.sv
// alu_seq: accumulator sequencer driving an external, shareable 4-bit ALU.
// Commands arrive on valid/ready, the result lands in acc/acc_hi/flags and is
// returned on a valid/ready response channel.
// Build option: ALU_SEQ_MUL_EN enables opcode 0x9 as a 4-cycle shift-add
// multiply through the ALU adder; without it 0x9 is rejected as illegal.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int         DATA_W  = 4,      // must match the ALU; only 4 is supported
   parameter logic [3:0] ACC_RST = 4'h0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [DATA_W-1:0] rsp_hi,
   output logic              rsp_zero,
   output logic              rsp_carry,
   output logic              rsp_sign,
   output logic              rsp_err,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alu_op,
   output logic              alu_l,
   input  logic [DATA_W-1:0] alu_r,
   input  logic              alu_zero,
   input  logic              alu_carry,
   input  logic              alu_sign
);

   state_t              r_state;
   logic                r_cmd_ready;
   logic                r_rsp_valid;
   logic                r_err;
   logic [2:0]          r_op_q;        // {L, ALUOp} of the latched command
   logic [DATA_W-1:0]   r_data_q;      // operand B / multiplicand
   logic [DATA_W-1:0]   r_acc;
   logic [DATA_W-1:0]   r_acc_hi;
   logic                r_zero;
   logic                r_carry;
   logic                r_sign;
   logic                w_accept;
   logic [DATA_W-1:0]   w_alu_a;
   logic [DATA_W-1:0]   w_alu_b;
   logic [1:0]          w_alu_op;
   logic                w_alu_l;

`ifdef ALU_SEQ_MUL_EN
   logic [DATA_W-1:0]   r_p_hi;        // partial product, upper half
   logic [DATA_W-1:0]   r_p_lo;        // multiplier bits shifting out / product low half
   logic [1:0]          r_cnt;         // iteration 0..3
   logic                w_mul_c;
   logic [DATA_W-1:0]   w_mul_s;
   logic [DATA_W-1:0]   w_mul_hi_nxt;
   logic [DATA_W-1:0]   w_mul_lo_nxt;
`endif

   assign w_accept = cmd_valid & r_cmd_ready;

   // ALU operand mux: EXEC uses acc/data, MUL uses the partial product, otherwise idle at zero
   always_comb begin
      w_alu_a  = {DATA_W{1'b0}};
      w_alu_b  = {DATA_W{1'b0}};
      w_alu_op = 2'b00;
      w_alu_l  = 1'b0;
      case (r_state)
         ST_EXEC: begin
            w_alu_a  = r_acc;
            w_alu_b  = r_data_q;
            w_alu_l  = r_op_q[2];
            w_alu_op = r_op_q[1:0];
         end
`ifdef ALU_SEQ_MUL_EN
         ST_MUL: begin
            w_alu_a  = r_p_hi;
            w_alu_b  = r_data_q;
            w_alu_l  = 1'b0;
            w_alu_op = ALUOP_ADD;
         end
`endif
         default: begin
            w_alu_a  = {DATA_W{1'b0}};
            w_alu_b  = {DATA_W{1'b0}};
            w_alu_op = 2'b00;
            w_alu_l  = 1'b0;
         end
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   // One shift-add step: add the multiplicand when the current multiplier bit is set, then shift right
   always_comb begin
      if (r_p_lo[0]) begin
         w_mul_c = alu_carry;
         w_mul_s = alu_r;
      end else begin
         w_mul_c = 1'b0;
         w_mul_s = r_p_hi;
      end
      w_mul_hi_nxt = {w_mul_c, w_mul_s[DATA_W-1:1]};
      w_mul_lo_nxt = {w_mul_s[0], r_p_lo[DATA_W-1:1]};
   end
`endif

   // Command FSM: latch on accept, sequence EXEC/MUL, hold the response until consumed
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_err       <= 1'b0;
         r_op_q      <= 3'd0;
         r_data_q    <= {DATA_W{1'b0}};
         r_acc       <= ACC_RST;
         r_acc_hi    <= ACC_RST;
         r_zero      <= 1'b0;
         r_carry     <= 1'b0;
         r_sign      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         r_p_hi      <= {DATA_W{1'b0}};
         r_p_lo      <= {DATA_W{1'b0}};
         r_cnt       <= 2'd0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op_q      <= cmd_op[2:0];
                  r_data_q    <= cmd_data;
                  r_cmd_ready <= 1'b0;
                  case (cmd_op)
                     OP_ADD, OP_SUB, OP_NEGA, OP_NEGB,
                     OP_LOG0, OP_LOG1, OP_LOG2, OP_LOG3: begin
                        r_err   <= 1'b0;
                        r_state <= ST_EXEC;
                     end
                     OP_LOAD: begin
                        r_acc       <= cmd_data;
                        r_err       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                     end
                     OP_CLR: begin
                        r_acc       <= {DATA_W{1'b0}};
                        r_acc_hi    <= {DATA_W{1'b0}};
                        r_zero      <= 1'b0;
                        r_carry     <= 1'b0;
                        r_sign      <= 1'b0;
                        r_err       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                     end
`ifdef ALU_SEQ_MUL_EN
                     OP_MUL: begin
                        r_p_hi  <= {DATA_W{1'b0}};
                        r_p_lo  <= r_acc;
                        r_cnt   <= 2'd0;
                        r_err   <= 1'b0;
                        r_state <= ST_MUL;
                     end
`endif
                     default: begin
                        // illegal opcode: report it, architectural state untouched
                        r_err       <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                     end
                  endcase
               end
            end
            ST_EXEC: begin
               r_acc  <= alu_r;
               r_zero <= alu_zero;
               // logic ops leave carry/sign alone; the ALU's flags are undefined for them
               if (!r_op_q[2]) begin
                  r_carry <= alu_carry;
                  r_sign  <= alu_sign;
               end
               r_rsp_valid <= 1'b1;
               r_state     <= ST_RESP;
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: begin
               r_p_hi <= w_mul_hi_nxt;
               r_p_lo <= w_mul_lo_nxt;
               r_cnt  <= r_cnt + 2'd1;
               if (r_cnt == 2'd3) begin
                  r_acc       <= w_mul_lo_nxt;
                  r_acc_hi    <= w_mul_hi_nxt;
                  r_zero      <= ({w_mul_hi_nxt, w_mul_lo_nxt} == {(2*DATA_W){1'b0}});
                  r_carry     <= (w_mul_hi_nxt != {DATA_W{1'b0}});
                  r_sign      <= w_mul_hi_nxt[DATA_W-1];
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end
            end
`endif
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_acc;
   assign rsp_hi    = r_acc_hi;
   assign rsp_zero  = r_zero;
   assign rsp_carry = r_carry;
   assign rsp_sign  = r_sign;
   assign rsp_err   = r_err;
   assign alu_a     = w_alu_a;
   assign alu_b     = w_alu_b;
   assign alu_op    = w_alu_op;
   assign alu_l     = w_alu_l;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq with an ALU model attached and a
// command-level reference model. Honours ALU_SEQ_MUL_EN if defined.
module tb_alu_seq;

`ifdef ALU_SEQ_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_op = 4'h0;
   logic [3:0] cmd_data = 4'h0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [3:0] rsp_data, rsp_hi;
   logic       rsp_zero, rsp_carry, rsp_sign, rsp_err;
   logic [3:0] alu_a, alu_b, alu_r;
   logic [1:0] alu_op;
   logic       alu_l, alu_zero, alu_carry, alu_sign;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_en  = 1'b0;
   bit pending = 1'b0;   // a command has been accepted and not yet answered
   int due     = 0;      // cycle number at which its response must be valid

   // reference state
   logic [3:0] m_acc, m_hi;
   logic       m_z, m_c, m_s, m_err;

   // last observed response
   logic [3:0] lr_data, lr_hi;
   logic       lr_z, lr_c, lr_s, lr_err;
   int         lr_lat;

   logic [3:0] junk;
   logic [4:0] w_alu;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      junk <= 4'($urandom);
   end

   alu_seq #(.DATA_W(4), .ACC_RST(4'h0)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_hi(rsp_hi),
      .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_sign(rsp_sign), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_l(alu_l),
      .alu_r(alu_r), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign)
   );

   // 4-bit ALU: returns {carry, result}. Logic ops: AND, OR, XOR, NOT A.
   function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
      logic [4:0] t;
      case (f)
         3'd0:    t = {1'b0, a} + {1'b0, b};
         3'd1:    t = {1'b0, a} + {1'b0, ~b} + 5'd1;
         3'd2:    t = {1'b0, ~a} + 5'd1;
         3'd3:    t = {1'b0, ~b} + 5'd1;
         3'd4:    t = {1'b0, a & b};
         3'd5:    t = {1'b0, a | b};
         3'd6:    t = {1'b0, a ^ b};
         default: t = {1'b0, ~a};
      endcase
      return t;
   endfunction

   // external ALU; carry/sign are garbage for logic ops so they must never be sampled
   always_comb begin
      w_alu    = alu_f(alu_a, alu_b, {alu_l, alu_op});
      alu_r    = w_alu[3:0];
      alu_zero = (w_alu[3:0] == 4'h0);
      if (alu_l) begin
         alu_carry = junk[0];
         alu_sign  = junk[1];
      end else begin
         alu_carry = w_alu[4];
         alu_sign  = w_alu[3];
      end
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_acc = 4'h0; m_hi = 4'h0;
      m_z = 1'b0; m_c = 1'b0; m_s = 1'b0; m_err = 1'b0;
   endtask

   // command-level effect and latency of one command
   task automatic model_apply(input logic [3:0] op, input logic [3:0] d, output int lat);
      logic [4:0] t;
      logic [7:0] p;
      if (op < 4'h8) begin
         t = alu_f(m_acc, d, op[2:0]);
         m_acc = t[3:0];
         m_z   = (t[3:0] == 4'h0);
         if (!op[2]) begin
            m_c = t[4];
            m_s = t[3];
         end
         m_err = 1'b0; lat = 2;
      end else if (op == 4'h8) begin
         m_acc = d; m_err = 1'b0; lat = 1;
      end else if (op == 4'h9 && MUL_EN) begin
         p = {4'h0, m_acc} * {4'h0, d};
         m_acc = p[3:0]; m_hi = p[7:4];
         m_z = (p == 8'h00); m_c = (p[7:4] != 4'h0); m_s = p[7];
         m_err = 1'b0; lat = 5;
      end else if (op == 4'hA) begin
         m_acc = 4'h0; m_hi = 4'h0; m_z = 1'b0; m_c = 1'b0; m_s = 1'b0;
         m_err = 1'b0; lat = 1;
      end else begin
         m_err = 1'b1; lat = 1;
      end
   endtask

   // per-cycle comparison of handshake, response fields and ALU drive against the model
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         if (pending && cyc < due) begin
            chk("busy_ready", cmd_ready, 1'b0);
            chk("busy_rsp_valid", rsp_valid, 1'b0);
         end else begin
            chk("alu_a_idle", alu_a, 4'h0);
            chk("alu_b_idle", alu_b, 4'h0);
            chk("alu_fn_idle", {alu_l, alu_op}, 3'd0);
            if (pending) begin
               chk("resp_ready", cmd_ready, 1'b0);
               chk("resp_valid", rsp_valid, 1'b1);
               chk("rsp_data", rsp_data, m_acc);
               chk("rsp_hi", rsp_hi, m_hi);
               chk("rsp_flags", {rsp_zero, rsp_carry, rsp_sign}, {m_z, m_c, m_s});
               chk("rsp_err", rsp_err, m_err);
            end else begin
               chk("idle_ready", cmd_ready, 1'b1);
               chk("idle_rsp_valid", rsp_valid, 1'b0);
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      pending = 1'b0;
      model_reset();
   endtask

   // issue one command; optionally reset rst_at cycles after accept; hold response `hold` cycles
   task automatic send(input logic [3:0] op, input logic [3:0] d, input int hold, input int rst_at);
      int lat;
      int k;
      chk("ready_at_send", cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_data = 4'($urandom);
      model_apply(op, d, lat);
      due = cyc + lat - 1;
      pending = 1'b1;
      if (rst_at >= 0) begin
         repeat (rst_at) begin @(posedge clk); #1; end
         do_reset();
         return;
      end
      k = 1;
      while (!rsp_valid && k < 12) begin
         @(posedge clk); #1;
         k++;
      end
      if (!rsp_valid) begin
         chk("rsp_timeout", rsp_valid, 1'b1);
         do_reset();
         return;
      end
      lr_lat = k;
      lr_data = rsp_data; lr_hi = rsp_hi; lr_z = rsp_zero;
      lr_c = rsp_carry; lr_s = rsp_sign; lr_err = rsp_err;
      for (int h = 0; h < hold; h++) begin
         cmd_valid = h[0];        // pulses that must be ignored while busy
         cmd_op = 4'h8; cmd_data = 4'($urandom);
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      pending = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_en = 1'b1;
      chk("reset_ready", cmd_ready, 1'b1);
      chk("reset_valid", rsp_valid, 1'b0);
      chk("reset_err", rsp_err, 1'b0);

      // add: 5 + 3
      send(4'h8, 4'h5, 0, -1);
      chk("load_lat", lr_lat, 8'd1);
      send(4'h0, 4'h3, 0, -1);
      chk("add_data", lr_data, 4'h8);
      chk("add_zcs", {lr_z, lr_c, lr_s}, 3'b001);
      chk("add_lat", lr_lat, 8'd2);

      // sub: 3 - 5, then a logic op keeps carry/sign
      send(4'h8, 4'h3, 0, -1);
      send(4'h1, 4'h5, 0, -1);
      chk("sub_data", lr_data, 4'hE);
      chk("sub_cs", {lr_c, lr_s}, 2'b01);
      send(4'h4, 4'h7, 0, -1);
      chk("and_data", lr_data, 4'h6);
      chk("and_cs_held", {lr_c, lr_s}, 2'b01);

      // multiply (or illegal 0x9 when multiply is not built)
      send(4'h8, 4'h7, 0, -1);
      send(4'h9, 4'h6, 0, -1);
      if (MUL_EN) begin
         chk("mul_data", lr_data, 4'hA);
         chk("mul_hi", lr_hi, 4'h2);
         chk("mul_zc", {lr_z, lr_c}, 2'b01);
         chk("mul_lat", lr_lat, 8'd5);
         send(4'h9, 4'h0, 0, -1);
         chk("mul0_zero", {lr_z, lr_data, lr_hi}, 9'h100);
      end else begin
         chk("mul_illegal_err", lr_err, 1'b1);
         chk("mul_illegal_data", lr_data, 4'h7);
         chk("mul_illegal_lat", lr_lat, 8'd1);
      end

      // stalled response with ignored command pulses
      send(4'hA, 4'h0, 3, -1);
      send(4'h8, 4'hC, 3, -1);
      chk("hold_data", lr_data, 4'hC);

      // reset mid-flight: mid-MUL iteration 2 or mid-EXEC
      send(4'h8, 4'h5, 0, -1);
      if (MUL_EN) send(4'h9, 4'h3, 0, 2);
      else        send(4'h0, 4'h3, 0, 0);
      chk("rst_mid_ready", cmd_ready, 1'b1);
      chk("rst_mid_valid", rsp_valid, 1'b0);
      send(4'h0, 4'h0, 0, -1);
      chk("rst_mid_acc", {lr_data, lr_hi}, 8'h00);

      // illegal opcode
      send(4'h8, 4'h9, 0, -1);
      send(4'hF, 4'h3, 0, -1);
      chk("illegal_err", lr_err, 1'b1);
      chk("illegal_data", lr_data, 4'h9);
      chk("illegal_lat", lr_lat, 8'd1);
      send(4'h8, 4'h1, 0, -1);
      chk("err_clears", lr_err, 1'b0);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         logic [3:0] op;
         int ra;
         op = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 10)) : 4'($urandom);
         ra = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 4)) : -1;
         send(op, 4'($urandom), int'($urandom_range(0, 3)), ra);
      end

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Accumulator sequencer that drives the 4-bit ALU from the controlling side.
- Accepts commands on a valid/ready interface and drives the ALU operand/operation inputs ({L, ALUOp}, A, B).
- Captures R/zero/carry/sign into an accumulator and flag register, then returns a response.
- Adds a multi-cycle 4x4 shift-add multiply built from repeated ALU adds. The ALU stays instantiated outside this block so it can be shared.

Parameters:
- DATA_W, 4, datapath width; must equal ALU width; only 4 supported.
- ACC_RST, 4'h0, reset value of acc and acc_hi.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  block can accept a command
- cmd_op  in  4  opcode
- cmd_data  in  4  operand B or load value
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_data  out  4  acc after the command
- rsp_hi  out  4  acc_hi (multiply high nibble)
- rsp_zero, rsp_carry, rsp_sign  out  1 each  flag register
- rsp_err  out  1  illegal opcode
- alu_a, alu_b  out  4 each  ALU operands
- alu_op  out  2  ALU ALUOp
- alu_l  out  1  ALU L (1 = logic)
- alu_r  in  4  ALU result
- alu_zero, alu_carry, alu_sign  in  1 each  ALU flags

Behaviour:
- Opcodes:
  - 0x0-0x7 ALU op, forwarded as {alu_l, alu_op} = cmd_op[2:0]. L=0: 00 A+B, 01 A-B, 10 -A, 11 -B. L=1: the ALU's logic ops.
  - 0x8 LOAD: acc <= data.
  - 0x9 MUL.
  - 0xA CLR: acc, acc_hi, flags <= 0.
  - 0xB-0xF illegal.
- States: IDLE, EXEC, MUL, RESP. cmd_ready = (state==IDLE). Accept = cmd_valid & cmd_ready; op and data latch on accept.
- IDLE -> EXEC for ALU op; -> MUL for MUL; -> RESP directly for LOAD/CLR/illegal.
- EXEC (1 cycle):
  - Drive alu_a=acc, alu_b=data_q, {alu_l, alu_op}=op_q.
  - At cycle end: acc <= alu_r, zero <= alu_zero.
  - If L=0: carry/sign <= alu_carry/alu_sign. If L=1: carry and sign hold their prior values; the ALU's X flags are never sampled.
  - Then -> RESP.
- MUL (exactly 4 cycles, iteration counter 0..3):
  - P_hi starts at 0, P_lo = acc, mcand = data_q.
  - Each cycle drives alu_a=P_hi, alu_b=mcand, alu_op=00, alu_l=0.
  - If P_lo[0]: {c, s} = {alu_carry, alu_r}; else {c, s} = {0, P_hi}.
  - Then {P_hi, P_lo} <= {c, s, P_lo[3:1]}.
  - After iteration 3: acc <= P_lo, acc_hi <= P_hi, zero <= (8-bit product == 0), carry <= (acc_hi != 0), sign <= P_hi[3]. Then -> RESP.
- ALU port drive: in IDLE and RESP, alu_a/alu_b/alu_op/alu_l are driven 0.
- RESP:
  - rsp_valid=1; rsp_* reflect registers and are stable while rsp_valid & !rsp_ready.
  - On rsp_ready -> IDLE. A new command is accepted no earlier than the following cycle.
- Latency (accept at cycle T):
  - ALU op: rsp_valid at T+2.
  - MUL: rsp_valid at T+5.
  - LOAD/CLR/illegal: rsp_valid at T+1.
- rsp_err: 1 only for an illegal opcode. An illegal opcode leaves acc, acc_hi and flags unchanged.
- acc_hi: written only by MUL and CLR.
- Reset, including mid-EXEC/MUL/RESP:
  - state=IDLE, acc=acc_hi=ACC_RST, flags=0, rsp_valid=0, rsp_err=0, cmd_ready=1 on the first cycle after reset deasserts.
  - Any in-flight command is dropped with no response.
- cmd_valid while !cmd_ready: ignored; no latch occurs.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: MUL (0x9) is implemented as above.
- Undefined: the MUL state and iteration counter are absent. 0x9 is treated as illegal (rsp_err=1, rsp_valid at T+1, no state change).

Decomposition:
- Shared package alu_seq_pkg holds:
  - opcode constants: OP_ADD..OP_LOG3 = 0x0-0x7, OP_LOAD, OP_MUL, OP_CLR
  - ALU function constants ALUOP_ADD/SUB/NEGA/NEGB
  - state enum
- No sub-module: the MUL shift register is about 20 lines and shares the ALU ports with EXEC, so everything stays in alu_seq.

Test Plan:
- LOAD 0x5 then op 0x0 with data 0x3 -> rsp_data=0x8, zero=0, carry=0, sign=1, rsp_valid 2 cycles after accept.
- LOAD 0x3 then op 0x1 with data 0x5 -> rsp_data=0xE, carry=0, sign=1. Then op 0x4 (L=1) -> carry and sign still 0 and 1 while acc updates.
- LOAD 0x7 then MUL with data 0x6 -> rsp_data=0xA, rsp_hi=0x2, carry=1, zero=0, rsp_valid 5 cycles after accept. MUL 0x0 -> zero=1.
- Hold rsp_ready low for 3 cycles -> rsp_valid and rsp_* stable and cmd_ready=0 throughout; cmd_valid pulses ignored.
- Assert rst during MUL iteration 2 -> next cycle cmd_ready=1, acc=0, no rsp_valid.
- Opcode 0xF (and 0x9 without ALU_SEQ_MUL_EN) -> rsp_err=1 at T+1, acc unchanged.
